// File: rtl/button_press_classifier_pkg.sv
// Shared state encodings and default timing constants for the
// button classifier and its neighbours (debouncer, score logic).
package button_press_classifier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_HELD  = 2'd2
   } state_e;

   localparam int unsigned CLK_HZ            = 10_000_000;
   localparam int unsigned LONG_CYCLES_DEF   = 10_000_000;
   localparam int unsigned REPEAT_CYCLES_DEF = 2_000_000;
   localparam int unsigned DEBOUNCE_CYCLES   = CLK_HZ / 100;

endpackage

// File: rtl/button_press_classifier_edge_detect.sv
// Registers the previous button level and flags rising/falling edges.
// btn_prev resets high so a button held through reset shows no rise.
module button_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic rise_o,
   output logic fall_o
);

   logic btn_prev;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_prev <= 1'b1;
      end else begin
         btn_prev <= btn_i;
      end
   end

   assign rise_o = btn_i & ~btn_prev;
   assign fall_o = ~btn_i & btn_prev;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short/long/repeat event pulses
// plus a pressed level, all registered.
module button_press_classifier
   import button_press_classifier_pkg::*;
#(
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_db_i,
   input  logic en_i,
   output logic short_press_o,
   output logic long_press_o,
   output logic repeat_o,
   output logic pressed_o
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   state_e           state;
   logic [CNT_W-1:0] timer;
   logic             rise;
   logic             fall;

   button_edge_detect u_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (button_db_i),
      .rise_o (rise),
      .fall_o (fall)
   );

   // In PRESS/HELD the previous level is always 1, so fall == release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         timer         <= '0;
         short_press_o <= 1'b0;
         long_press_o  <= 1'b0;
         repeat_o      <= 1'b0;
         pressed_o     <= 1'b0;
      end else begin
         short_press_o <= 1'b0;
         long_press_o  <= 1'b0;
         repeat_o      <= 1'b0;
         if (!en_i) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pressed_o <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state     <= ST_PRESS;
                     timer     <= '0;
                     pressed_o <= 1'b1;
                  end
               end
               ST_PRESS: begin
                  if (fall) begin
                     short_press_o <= 1'b1;
                     state         <= ST_IDLE;
                     pressed_o     <= 1'b0;
                  end else if (timer == LONG_LAST) begin
                     long_press_o <= 1'b1;
                     state        <= ST_HELD;
                     timer        <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               ST_HELD: begin
                  if (fall) begin
                     state     <= ST_IDLE;
                     pressed_o <= 1'b0;
                  end else if (REPEAT_EN) begin
                     if (timer == REP_LAST) begin
                        repeat_o <= 1'b1;
                        timer    <= '0;
                     end else begin
                        timer <= timer + 1'b1;
                     end
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  timer     <= '0;
                  pressed_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: hold-length reference model feeds expected events,
// a negedge monitor compares pulses and pressed level every cycle.
module tb_button_press_classifier;

   localparam int L = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;
   logic en  = 1'b1;
   logic short_press, long_press, rpt, pressed;

   always #5 clk = ~clk;

   button_press_classifier #(
      .CNT_W         (24),
      .LONG_CYCLES   (L),
      .REPEAT_CYCLES (R),
      .REPEAT_EN     (1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .button_db_i   (btn),
      .en_i          (en),
      .short_press_o (short_press),
      .long_press_o  (long_press),
      .repeat_o      (rpt),
      .pressed_o     (pressed)
   );

   typedef struct {
      int c;
      int k;
   } ev_t;

   ev_t ev_q[$];
   ev_t pr_q[$];
   int  cyc      = 0;
   int  checks   = 0;
   int  failures = 0;

   bit  m_active = 1'b0;
   bit  m_prev   = 1'b1;
   int  m_start  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model: a press is "on" from the accepted rise; its outcome
   // depends only on how many edges the button stayed high.
   task automatic step(input bit r, input bit b, input bit e);
      int ed;
      int h;
      int kind;
      @(negedge clk);
      rst  = r;
      btn  = b;
      en   = e;
      ed   = cyc + 1;
      kind = 0;
      if (r) begin
         m_active = 1'b0;
         m_prev   = 1'b1;
      end else begin
         if (!m_active) begin
            if (e && b && !m_prev) begin
               m_active = 1'b1;
               m_start  = ed;
            end
         end else if (!e) begin
            m_active = 1'b0;
         end else begin
            h = ed - m_start;
            if (!b) begin
               if (h <= L) kind = 1;
               m_active = 1'b0;
            end else if (h == L) begin
               kind = 2;
            end else if (h > L && ((h - L) % R) == 0) begin
               kind = 3;
            end
         end
         m_prev = b;
      end
      if (kind != 0) ev_q.push_back('{ed, kind});
      pr_q.push_back('{ed, int'(m_active)});
   endtask

   task automatic run(input bit b, input int n);
      for (int i = 0; i < n; i++) step(1'b0, b, 1'b1);
   endtask

   int  ek;
   int  ak;
   int  ep;
   ev_t t_ev;

   always @(negedge clk) begin
      ek = 0;
      if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
         t_ev = ev_q.pop_front();
         ek   = t_ev.k;
      end
      if ($isunknown({short_press, long_press, rpt}))
         ak = 8;
      else if (int'(short_press) + int'(long_press) + int'(rpt) > 1)
         ak = 7;
      else if (short_press)
         ak = 1;
      else if (long_press)
         ak = 2;
      else if (rpt)
         ak = 3;
      else
         ak = 0;
      checks++;
      if (ak != ek) begin
         failures++;
         $display("FAIL pulse cyc=%0d got=%0d exp=%0d", cyc, ak, ek);
      end
      if (pr_q.size() > 0 && pr_q[0].c == cyc) begin
         t_ev = pr_q.pop_front();
         ep   = t_ev.k;
         checks++;
         if (pressed !== ep[0]) begin
            failures++;
            $display("FAIL pressed cyc=%0d got=%b exp=%0d", cyc, pressed, ep);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      run(1'b0, 3);
      // short press
      run(1'b1, 3);
      run(1'b0, 5);
      // long hold with repeats
      run(1'b1, 20);
      run(1'b0, 5);
      // boundary: 8 high -> short, 9 high -> long
      run(1'b1, 8);
      run(1'b0, 3);
      run(1'b1, 9);
      run(1'b0, 3);
      // 1-cycle press
      run(1'b1, 1);
      run(1'b0, 4);
      // held through reset
      run(1'b1, 2);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
      run(1'b1, 14);
      run(1'b0, 2);
      run(1'b1, 3);
      run(1'b0, 3);
      // enable abort
      run(1'b1, 3);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
      run(1'b1, 12);
      run(1'b0, 2);
      run(1'b1, 2);
      run(1'b0, 3);
      // reset mid-hold
      run(1'b1, 12);
      step(1'b1, 1'b1, 1'b1);
      run(1'b1, 12);
      run(1'b0, 3);
      // random traffic
      for (int s = 0; s < 120; s++) begin
         int  n;
         bit  lvl;
         lvl = s[0];
         n   = $urandom_range(1, 22);
         for (int i = 0; i < n; i++) begin
            bit r;
            bit e;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 39) != 0);
            step(r, lvl, e);
         end
      end
      run(1'b0, 4);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (ev_q.size() != 0 || pr_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d/%0d exp=0/0", ev_q.size(), pr_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
